e_mdu_ctrl: RTL and testbench

//   Execute-stage multiply/divide sequencer for the 5-stage MIPS pipeline. It accepts

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/mdu_arith.sv | 51 +++++
 rtl/e_mdu_ctrl.sv | 107 ++++++++++
 tb/tb_e_mdu_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared op encodings, default latencies and FSM state type for the execute-stage MDU.
package mdu_pkg;

  typedef logic [3:0] mdu_op_t;

  localparam mdu_op_t MDU_NONE  = 4'd0;
  localparam mdu_op_t MDU_MULT  = 4'd1;
  localparam mdu_op_t MDU_MULTU = 4'd2;
  localparam mdu_op_t MDU_DIV   = 4'd3;
  localparam mdu_op_t MDU_DIVU  = 4'd4;
  localparam mdu_op_t MDU_MFHI  = 4'd5;
  localparam mdu_op_t MDU_MFLO  = 4'd6;
  localparam mdu_op_t MDU_MTHI  = 4'd7;
  localparam mdu_op_t MDU_MTLO  = 4'd8;

  localparam int unsigned MDU_MULT_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES  = 10;

  typedef enum logic {StIdle, StBusy} mdu_state_e;

  function automatic logic is_mdu_arith(input mdu_op_t op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing the HI/LO values an MDU op would commit.
module mdu_arith
  import mdu_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] hi_next,
  output logic [W-1:0] lo_next,
  output logic         div0
);

  logic [2*W-1:0] prod_u, prod_s;
  logic           sgn_div, a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag, b_safe, q_mag, r_mag, q_val, r_val;

  // Low 2W bits of a product of sign-extended operands equal the signed product.
  assign prod_u = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign prod_s = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};

  // Signed divide via magnitudes so the most-negative / -1 case wraps instead of trapping.
  assign sgn_div = (op == MDU_DIV);
  assign a_neg   = sgn_div & a[W-1];
  assign b_neg   = sgn_div & b[W-1];
  assign a_mag   = a_neg ? -a : a;
  assign b_mag   = b_neg ? -b : b;
  assign b_safe  = (b_mag == '0) ? W'(1) : b_mag;
  assign q_mag   = a_mag / b_safe;
  assign r_mag   = a_mag % b_safe;
  assign q_val   = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign r_val   = a_neg ? -r_mag : r_mag;

  always_comb begin
    hi_next = '0;
    lo_next = '0;
    div0    = 1'b0;
    unique case (op)
      MDU_MULT:  {hi_next, lo_next} = prod_s;
      MDU_MULTU: {hi_next, lo_next} = prod_u;
      MDU_DIV, MDU_DIVU: begin
        hi_next = r_val;
        lo_next = q_val;
        div0    = (b == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu_ctrl.sv
// Execute-stage MDU sequencer: fixed-latency busy counter, HI/LO registers, MF*/MT* and D stall.
module e_mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned W           = 32,
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [3:0]   E_mdu_op,
  input  logic [W-1:0] E_V1_f,
  input  logic [W-1:0] E_V2_f,
  input  logic         D_mdu_use,
  output logic [W-1:0] E_mdu_rd,
  output logic         E_mdu_busy,
  output logic         D_mdu_stall,
  output logic [W-1:0] HI,
  output logic [W-1:0] LO
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  mdu_state_e     state_q;
  logic [CntW-1:0] cnt_q;
  logic           busy_q, pend_wr_q;
  logic [W-1:0]   hi_q, lo_q, pend_hi_q, pend_lo_q;
  logic [W-1:0]   hi_next, lo_next;
  logic           div0, start, is_mul;

  mdu_arith #(
    .W (W)
  ) u_arith (
    .op      (E_mdu_op),
    .a       (E_V1_f),
    .b       (E_V2_f),
    .hi_next (hi_next),
    .lo_next (lo_next),
    .div0    (div0)
  );

  assign start  = is_mdu_arith(E_mdu_op) & ~busy_q;
  assign is_mul = (E_mdu_op == MDU_MULT) || (E_mdu_op == MDU_MULTU);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StBusy;
            busy_q    <= 1'b1;
            cnt_q     <= is_mul ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
            pend_hi_q <= hi_next;
            pend_lo_q <= lo_next;
            // Divide by zero still burns the full latency but leaves HI/LO alone.
            pend_wr_q <= ~div0;
          end else if (E_mdu_op == MDU_MTHI) begin
            hi_q <= E_V1_f;
          end else if (E_mdu_op == MDU_MTLO) begin
            lo_q <= E_V1_f;
          end
        end
        StBusy: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            if (pend_wr_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    E_mdu_rd = '0;
    if (E_mdu_op == MDU_MFHI) begin
      E_mdu_rd = hi_q;
    end else if (E_mdu_op == MDU_MFLO) begin
      E_mdu_rd = lo_q;
    end
  end

  // Gated by reset so every output reads zero while reset is held.
  assign D_mdu_stall = reset_n & D_mdu_use & (start | busy_q);
  assign E_mdu_busy  = busy_q;
  assign HI          = hi_q;
  assign LO          = lo_q;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Directed bench for e_mdu_ctrl: default latencies plus a 1/1-cycle instance.
module tb_e_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk;
  logic        reset_n, reset1_n;
  logic [3:0]  op, op1;
  logic [31:0] v1, v2, a1, b1;
  logic        use_d, use1;
  logic [31:0] rd, hi, lo, rd1, hi1, lo1;
  logic        busy, stall, busy1, stall1;

  int n_checks = 0;
  int n_errors = 0;

  e_mdu_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .E_mdu_op    (op),
    .E_V1_f      (v1),
    .E_V2_f      (v2),
    .D_mdu_use   (use_d),
    .E_mdu_rd    (rd),
    .E_mdu_busy  (busy),
    .D_mdu_stall (stall),
    .HI          (hi),
    .LO          (lo)
  );

  e_mdu_ctrl #(
    .W           (32),
    .MULT_CYCLES (1),
    .DIV_CYCLES  (1)
  ) dut1 (
    .clk         (clk),
    .reset_n     (reset1_n),
    .E_mdu_op    (op1),
    .E_V1_f      (a1),
    .E_V2_f      (b1),
    .D_mdu_use   (use1),
    .E_mdu_rd    (rd1),
    .E_mdu_busy  (busy1),
    .D_mdu_stall (stall1),
    .HI          (hi1),
    .LO          (lo1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one arithmetic op for a single cycle, then measure busy length and final HI/LO.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] ehi,
                        input logic [31:0] elo);
    int cyc;
    op = o;
    v1 = a;
    v2 = b;
    #1;
    check({tag, "_idle"}, busy, 0);
    step();
    op  = MDU_NONE;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      step();
    end
    check({tag, "_cycles"}, cyc, n);
    check({tag, "_hi"}, hi, ehi);
    check({tag, "_lo"}, lo, elo);
  endtask

  initial begin
    int cyc, stalls;
    reset_n  = 1'b0;
    reset1_n = 1'b0;
    op       = MDU_MULT;
    v1       = 32'd1;
    v2       = 32'd1;
    use_d    = 1'b1;
    op1      = MDU_NONE;
    a1       = '0;
    b1       = '0;
    use1     = 1'b0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_rd", rd, 0);
    op    = MDU_NONE;
    use_d = 1'b0;
    @(negedge clk);
    reset_n  = 1'b1;
    reset1_n = 1'b1;
    step();

    // 1: signed multiply and MFLO/MFHI readback
    run_op("mult", MDU_MULT, 32'hFFFF_FFFD, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    op = MDU_MFLO;
    #1;
    check("mflo", rd, 32'hFFFF_FFF1);
    op = MDU_MFHI;
    #1;
    check("mfhi", rd, 32'hFFFF_FFFF);
    op = MDU_NONE;
    #1;
    check("rd_none", rd, 0);
    step();
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h1);

    // 2: divides
    run_op("divu", MDU_DIVU, 32'd17, 32'd5, 10, 32'd2, 32'd3);
    run_op("div_neg", MDU_DIV, 32'hFFFF_FFEF, 32'd5, 10, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run_op("div_wrap", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

    // 3: MTHI/MTLO then divide by zero leaves them intact
    op = MDU_MTHI;
    v1 = 32'h1234;
    step();
    op = MDU_MTLO;
    v1 = 32'h5678;
    step();
    op = MDU_NONE;
    check("mthi", hi, 32'h1234);
    check("mtlo", lo, 32'h5678);
    run_op("div0", MDU_DIV, 32'd7, 32'd0, 10, 32'h1234, 32'h5678);

    // 4: stall with an MDU op in D; a second MULT held in E while busy is ignored
    op    = MDU_MULT;
    v1    = 32'd2;
    v2    = 32'd3;
    use_d = 1'b1;
    #1;
    check("stall_start", stall, 1);
    step();
    v1     = 32'd100;
    v2     = 32'd100;
    cyc    = 0;
    stalls = 0;
    while (busy && cyc < 40) begin
      cyc++;
      if (stall) stalls++;
      step();
    end
    check("stall_busy_cycles", cyc, 5);
    check("stall_cycles", stalls, 5);
    op = MDU_NONE;
    #1;
    check("stall_release", stall, 0);
    check("held_mult_hi", hi, 0);
    check("held_mult_lo", lo, 32'd6);
    use_d = 1'b0;
    step();

    // 5: async reset mid-divide aborts without commit
    op = MDU_DIV;
    v1 = 32'd100;
    v2 = 32'd7;
    step();
    op = MDU_NONE;
    step();
    step();
    step();
    check("pre_reset_busy", busy, 1);
    #3;
    reset_n = 1'b0;
    #1;
    check("areset_busy", busy, 0);
    check("areset_hi", hi, 0);
    check("areset_lo", lo, 0);
    #2;
    reset_n = 1'b1;
    for (int i = 0; i < 15; i++) step();
    check("post_reset_busy", busy, 0);
    check("post_reset_hi", hi, 0);
    check("post_reset_lo", lo, 0);

    // 6: single-cycle latencies, back-to-back every 2 cycles
    op1 = MDU_MULT;
    a1  = 32'd6;
    b1  = 32'd7;
    #1;
    check("p1_idle", busy1, 0);
    step();
    check("p1_busy_a", busy1, 1);
    a1 = 32'd3;
    b1 = 32'hFFFF_FFFE;
    step();
    check("p1_done_a", busy1, 0);
    check("p1_lo_a", lo1, 32'd42);
    check("p1_hi_a", hi1, 0);
    step();
    check("p1_busy_b", busy1, 1);
    op1 = MDU_DIV;
    a1  = 32'hFFFF_FFF9;
    b1  = 32'd2;
    step();
    check("p1_done_b", busy1, 0);
    check("p1_lo_b", lo1, 32'hFFFF_FFFA);
    check("p1_hi_b", hi1, 32'hFFFF_FFFF);
    step();
    check("p1_busy_c", busy1, 1);
    op1 = MDU_NONE;
    step();
    check("p1_done_c", busy1, 0);
    check("p1_lo_c", lo1, 32'hFFFF_FFFD);
    check("p1_hi_c", hi1, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
